// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// Double-flop synchronises rx, qualifies the start bit at mid-bit, samples
// each data bit at its centre and checks the stop bit. A good frame updates
// dout with a one-cycle valid; a bad stop bit gives a one-cycle frame_err and
// parks in BREAK until the line returns high.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int H     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_valid;
  logic                 r_ferr;

  assign w_rx_s    = r_sync2;
  assign dout      = r_dout;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: timing is anchored at start-bit detection only; strobes are
  // single-cycle because they default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit   <= r_bit + BIT_ONE;
            if (r_bit == BIT_LAST) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_dout  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_BREAK: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
